// File: rtl/axi_memory_slave_pkg.sv
// rtl/axi_memory_slave_pkg.sv - response codes and FSM state types for axi_memory_slave
package axi_memory_slave_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

endpackage

// File: rtl/axi_mem_array.sv
// rtl/axi_mem_array.sv - word storage: synchronous write, asynchronous read, asynchronous clear
module axi_mem_array #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_SIZE   = 32,
  parameter int IDX_W      = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [IDX_W-1:0]      raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_SIZE; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read before write: a same-cycle write is visible from the next cycle.
  assign rdata = mem[raddr];

endmodule

// File: rtl/axi_memory_slave.sv
// rtl/axi_memory_slave.sv - word-addressed INCR burst memory slave with independent write/read FSMs
// Optional AXI_MEM_BOUNDS_CHECK_EN: out-of-range beats are dropped, read as 0 and fail the write response.
module axi_memory_slave
  import axi_memory_slave_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_SIZE   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic [7:0]            awlen,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  wlast,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic [7:0]            arlen,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rlast,
  output logic                  rvalid,
  input  logic                  rready
);

  localparam int IDX_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
  localparam logic [ADDR_WIDTH-1:0] DEPTH = ADDR_WIDTH'(MEM_SIZE);

  w_state_t              w_state;
  r_state_t              r_state;
  logic [ADDR_WIDTH-1:0] w_addr, r_addr;
  logic [7:0]            w_len, w_cnt, r_len, r_cnt;
  logic                  w_err, w_ok_beat, r_ok_beat, w_done, mem_we;
  logic [IDX_W-1:0]      w_idx, r_idx;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [ID_WIDTH-1:0]   unused_id;

  assign unused_id = '0;
  assign w_idx     = IDX_W'(w_addr % DEPTH);
  assign r_idx     = IDX_W'(r_addr % DEPTH);

`ifdef AXI_MEM_BOUNDS_CHECK_EN
  assign w_ok_beat = (w_addr < DEPTH);
  assign r_ok_beat = (r_addr < DEPTH);
`else
  assign w_ok_beat = 1'b1;
  assign r_ok_beat = 1'b1;
`endif

  // A burst ends on the counted last beat or on an early wlast, whichever comes first.
  assign w_done = (w_cnt == w_len) || wlast;
  assign mem_we = (w_state == W_DATA) && wvalid && w_ok_beat;
  assign rdata  = (rvalid && r_ok_beat) ? mem_rdata : '0;

  axi_mem_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .MEM_SIZE  (MEM_SIZE),
    .IDX_W     (IDX_W)
  ) u_array (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (mem_we),
    .waddr(w_idx),
    .wdata(wdata),
    .raddr(r_idx),
    .rdata(mem_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state <= W_IDLE;
      w_addr  <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_err   <= 1'b0;
      awready <= 1'b1;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= RESP_OKAY;
    end else begin
      case (w_state)
        W_IDLE: if (awvalid) begin
          w_addr  <= awaddr;
          w_len   <= awlen;
          w_cnt   <= '0;
          w_err   <= 1'b0;
          awready <= 1'b0;
          wready  <= 1'b1;
          w_state <= W_DATA;
        end
        W_DATA: if (wvalid) begin
          w_addr <= w_addr + ADDR_WIDTH'(1);
          w_cnt  <= w_cnt + 8'd1;
          w_err  <= w_err | ~w_ok_beat;
          if (w_done) begin
            wready  <= 1'b0;
            bvalid  <= 1'b1;
            bresp   <= ((w_cnt == w_len) && wlast && !w_err && w_ok_beat) ? RESP_OKAY : RESP_SLVERR;
            w_state <= W_RESP;
          end
        end
        W_RESP: if (bready) begin
          bvalid  <= 1'b0;
          bresp   <= RESP_OKAY;
          awready <= 1'b1;
          w_state <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= R_IDLE;
      r_addr  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      arready <= 1'b1;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: if (arvalid) begin
          r_addr  <= araddr;
          r_len   <= arlen;
          r_cnt   <= '0;
          arready <= 1'b0;
          rvalid  <= 1'b1;
          rlast   <= (arlen == 8'd0);
          r_state <= R_DATA;
        end
        R_DATA: if (rready) begin
          if (rlast) begin
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            arready <= 1'b1;
            r_state <= R_IDLE;
          end else begin
            r_addr <= r_addr + ADDR_WIDTH'(1);
            r_cnt  <= r_cnt + 8'd1;
            rlast  <= ((r_cnt + 8'd1) == r_len);
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_memory_slave.sv
// tb/tb_axi_memory_slave.sv - randomized scoreboard bench for axi_memory_slave
// Honours AXI_MEM_BOUNDS_CHECK_EN in its reference model.
`timescale 1ns/1ps
module tb_axi_memory_slave;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MS = 32;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
`ifdef AXI_MEM_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] awaddr = '0, araddr = '0;
  logic [7:0]    awlen = '0, arlen = '0;
  logic          awvalid = 1'b0, wlast = 1'b0, wvalid = 1'b0, bready = 1'b0;
  logic          arvalid = 1'b0, rready = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic          awready, wready, bvalid, arready, rlast, rvalid;
  logic [1:0]    bresp;
  logic [DW-1:0] rdata;

  always #5 clk = ~clk;

  axi_memory_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(4), .MEM_SIZE(MS)) dut (
    .clk(clk), .rst_n(rst_n),
    .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  int            tests = 0;
  int            fails = 0;
  logic [DW-1:0] model [MS];
  logic [DW:0]   rq [$];
  logic [1:0]    bq [$];
  logic [DW-1:0] wbuf [256];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
    if (BOUNDS && a >= AW'(MS)) return '0;
    return model[a % AW'(MS)];
  endfunction

  // Monitor: compares every presented read beat and write response against the queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rvalid) begin
        check("r_expected", rq.size() > 0, 1);
        if (rq.size() > 0) begin
          check("rdata", rdata, rq[0][DW-1:0]);
          check("rlast", rlast, rq[0][DW]);
          if (rready) void'(rq.pop_front());
        end
      end else begin
        check("rdata_idle_zero", rdata, 0);
      end
      if (bvalid && bready) begin
        check("b_expected", bq.size() > 0, 1);
        if (bq.size() > 0) check("bresp", bresp, bq.pop_front());
      end
    end
  end

  task automatic do_write(input logic [AW-1:0] addr, input int len, input int wl_beat, input bit stall);
    int            nb;
    bit            err, hs;
    logic [AW-1:0] a;
    nb  = (wl_beat >= 0 && wl_beat < len) ? wl_beat + 1 : len + 1;
    err = 1'b0;
    for (int i = 0; i < nb; i++) begin
      a = addr + AW'(i);
      if (BOUNDS && a >= AW'(MS)) err = 1'b1;
      else model[a % AW'(MS)] = wbuf[i];
    end
    bq.push_back((wl_beat == len && !err) ? OKAY : SLVERR);

    awaddr = addr; awlen = 8'(len); awvalid = 1'b1; hs = 1'b0;
    for (int k = 0; k < 20 && !hs; k++) begin
      @(negedge clk); hs = awready; @(posedge clk); #1;
    end
    awvalid = 1'b0; awaddr = $urandom; awlen = 8'($urandom);
    check("aw_handshake", hs, 1);
    check("aw_to_wready", wready, 1);

    for (int i = 0; i < nb; i++) begin
      if (stall) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      wdata = wbuf[i]; wlast = (i == wl_beat); wvalid = 1'b1; hs = 1'b0;
      for (int k = 0; k < 20 && !hs; k++) begin
        @(negedge clk); hs = wready; @(posedge clk); #1;
      end
      wvalid = 1'b0; wlast = 1'b0;
      check("w_handshake", hs, 1);
    end
    check("last_to_bvalid", bvalid, 1);

    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    bready = 1'b1; hs = 1'b0;
    for (int k = 0; k < 20 && !hs; k++) begin
      @(negedge clk); hs = bvalid; @(posedge clk); #1;
    end
    bready = 1'b0;
    check("b_handshake", hs, 1);
    check("w_idle_awready", awready, 1);
  endtask

  // mode 0: rready held high, 1: toggles 1/0, 2: random
  task automatic do_read(input logic [AW-1:0] addr, input int len, input int mode);
    int beats, cyc;
    bit hs, last;
    for (int i = 0; i <= len; i++) rq.push_back({i == len, model_rd(addr + AW'(i))});

    araddr = addr; arlen = 8'(len); arvalid = 1'b1; hs = 1'b0;
    for (int k = 0; k < 20 && !hs; k++) begin
      @(negedge clk); hs = arready; @(posedge clk); #1;
    end
    arvalid = 1'b0;
    check("ar_handshake", hs, 1);
    check("ar_to_rvalid", rvalid, 1);

    beats = 0; cyc = 0; last = 1'b0;
    for (int c = 0; c < 600 && !last; c++) begin
      rready = (mode == 0) ? 1'b1 : (mode == 1) ? ((c % 2) == 0) : 1'($urandom % 2);
      @(negedge clk);
      if (rvalid && rready) begin beats++; last = rlast; end
      @(posedge clk); #1;
      cyc++;
    end
    rready = 1'b0;
    check("r_beats", beats, len + 1);
    if (mode == 0) check("r_throughput_cycles", cyc, len + 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, r, wl;
    logic [AW-1:0] a;
    repeat (3) @(posedge clk);
    #1;
    check("rst_awready", awready, 1);
    check("rst_arready", arready, 1);
    check("rst_wready", wready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_bresp", bresp, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rlast", rlast, 0);
    check("rst_rdata", rdata, 0);
    for (int i = 0; i < MS; i++) model[i] = '0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    wbuf[0] = 32'hA5A5A5A5; wbuf[1] = 32'h5A5A5A5A; wbuf[2] = 32'h12345678; wbuf[3] = 32'h87654321;
    do_write(0, 3, 3, 1'b0);
    do_read(0, 3, 0);
    do_read(0, 3, 1);

    for (int i = 0; i < 4; i++) wbuf[i] = $urandom;
    do_write(30, 3, 3, 1'b0);
    do_read(28, 7, 0);
    do_read(0, 3, 0);

    for (int i = 0; i < 4; i++) wbuf[i] = $urandom;
    do_write(8, 3, 1, 1'b0);
    do_read(8, 3, 0);

    for (int n = 0; n < 40; n++) begin
      a   = AW'($urandom_range(0, MS + 3));
      len = $urandom_range(0, 7);
      if (n % 2 == 0) begin
        r  = $urandom_range(0, 7);
        wl = (r < 5) ? len : (r == 5) ? -1 : $urandom_range(0, len);
        for (int i = 0; i <= len; i++) wbuf[i] = $urandom;
        do_write(a, len, wl, 1'b1);
      end else begin
        do_read(a, len, 2);
      end
    end

    do_read(0, 7, 0);
    araddr = 0; arlen = 8'd7; arvalid = 1'b1;
    for (int i = 0; i <= 7; i++) rq.push_back({i == 7, model_rd(AW'(i))});
    @(posedge clk); #1;
    arvalid = 1'b0; rready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("mid_read_rvalid_before_reset", rvalid, 1);
    rst_n = 1'b0;
    #1;
    check("reset_rvalid", rvalid, 0);
    check("reset_rdata", rdata, 0);
    check("reset_arready", arready, 1);
    rq.delete();
    rready = 1'b0;
    for (int i = 0; i < MS; i++) model[i] = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_read(0, MS - 1, 2);

    repeat (3) @(posedge clk);
    #1;
    check("rq_drained", rq.size(), 0);
    check("bq_drained", bq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axi_memory_slave.md
# axi_memory_slave

Word-addressed AXI4-style burst memory slave, `MEM_SIZE` words of `DATA_WIDTH` bits. It serves INCR bursts on independent write and read channels. It sits behind an AXI master as scratch and frame storage and as a bus-level verification target. ID, size, burst-type and strobe signals are not part of the interface: every beat is one full word, and the address increments by one word per beat.

## Interface
- `ADDR_WIDTH`, 32: address width; the address is a word index, not a byte address.
- `DATA_WIDTH`, 32: word width.
- `ID_WIDTH`, 4: reserved for ID support; unused, kept for instantiation compatibility.
- `MEM_SIZE`, 32: depth in words.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `awaddr` input `ADDR_WIDTH`: write burst start word address.
- `awlen` input 8: write beats minus 1.
- `awvalid` input 1, `awready` output 1: write address handshake.
- `wdata` input `DATA_WIDTH`: write beat data.
- `wlast` input 1: master's last-beat marker.
- `wvalid` input 1, `wready` output 1: write data handshake.
- `bresp` output 2: write response, 00 OKAY, 10 SLVERR.
- `bvalid` output 1, `bready` input 1: write response handshake.
- `araddr` input `ADDR_WIDTH`: read burst start word address.
- `arlen` input 8: read beats minus 1.
- `arvalid` input 1, `arready` output 1: read address handshake.
- `rdata` output `DATA_WIDTH`: read beat data.
- `rlast` output 1: last read beat.
- `rvalid` output 1, `rready` input 1: read data handshake.

## Operation
- Write FSM states are W_IDLE, W_DATA and W_RESP.
  - W_IDLE: `awready`=1. On `awvalid`&&`awready`, latch `awaddr` and `awlen`, clear the beat counter, go to W_DATA.
  - W_DATA: `wready`=1. Each `wvalid`&&`wready` writes `wdata` to mem[addr], then addr+1 and count+1.
  - W_DATA, beat where count==len: go to W_RESP. `bresp`=OKAY if `wlast` was 1 on that beat, else SLVERR.
  - W_DATA, `wlast` before count==len: early termination. Go to W_RESP with SLVERR. Beats already written stay written.
  - W_RESP: `bvalid`=1 until `bready`, then W_IDLE.
- `awaddr` and `awlen` are ignored outside W_IDLE.
- Read FSM states are R_IDLE and R_DATA.
  - R_IDLE: `arready`=1. On handshake, latch `araddr` and `arlen`, go to R_DATA.
  - R_DATA: `rvalid`=1, `rdata`=mem[addr], `rlast`=(count==len).
  - R_DATA: each `rvalid`&&`rready` advances addr and count. The handshake on the `rlast` beat returns to R_IDLE.
- `rdata`=0 when `rvalid`=0.
- Address mapping: word index modulo `MEM_SIZE`; the burst wraps past the top.
- Read and write FSMs run concurrently. A read of a word written in the same cycle returns the old value; the new value is visible from the next cycle.
- Reset clears all memory words to 0 and forces both FSMs to idle.

## Timing
- Reset values: `awready`=1, `arready`=1, `wready`=0, `bvalid`=0, `bresp`=00, `rvalid`=0, `rlast`=0, `rdata`=0.
- Address handshake to first `wready` or `rvalid`: 1 cycle.
- Throughput: one beat per cycle while the master keeps valid/ready high.
- Last write beat to `bvalid`: 1 cycle.
- Stalls: low `wvalid` or `rready` holds state. `rdata` and `rlast` are stable while stalled.
- Reset mid-burst aborts the burst. No response is issued.

## Configuration
- `AXI_MEM_BOUNDS_CHECK_EN` defined:
  - a beat whose address is ≥ `MEM_SIZE` does not write;
  - such a beat reads as 0;
  - any such write beat forces `bresp`=SLVERR.
- Undefined: addresses wrap modulo `MEM_SIZE` with no error.

## Structure
- Package `axi_memory_slave_pkg`:
  - response constants `RESP_OKAY`=2'b00 and `RESP_SLVERR`=2'b10;
  - write-state enum and read-state enum.
- Sub-module `axi_mem_array`: storage with one synchronous write port, one asynchronous read port and asynchronous clear.
- Top level holds the two FSMs, address registers and beat counters.

## Test plan
- Write at 0, `awlen`=3, data A5A5A5A5, 5A5A5A5A, 12345678, 87654321, `wlast` on beat 4 -> `bvalid` one cycle after beat 4, `bresp`=00.
- Read at 0, `arlen`=3, `rready`=1 -> four consecutive beats A5A5A5A5, 5A5A5A5A, 12345678, 87654321; `rlast` on the 4th only.
- Read with `rready` toggling 1/0 -> the same 4 values, `rdata` held during stalls, no skipped beats.
- Write at 30, `awlen`=3:
  - macro undefined: words land at 30, 31, 0, 1, `bresp`=00;
  - macro defined: words 32 and 33 are dropped, `bresp`=10.
- Write with `wlast` on beat 2 of `awlen`=3 -> `bresp`=10; only 2 words written.
- Assert `rst_n` mid read burst -> `rvalid`=0 immediately; memory reads 0 after release.
